// File: rtl/rsa_stream_wrapper_if.sv
// Byte-stream channels of rsa_stream_wrapper: inbound operand bytes and outbound plaintext bytes.
// Signal names carry the wrapper's point of view (i_ = into the wrapper, o_ = out of it).
interface rsa_stream_wrapper_if;
  logic [7:0] i_in_data;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] o_out_data;
  logic       o_out_valid;
  logic       i_out_ready;

  modport slave (
    input  i_in_data, i_in_valid, i_out_ready,
    output o_in_ready, o_out_data, o_out_valid
  );

  modport master (
    output i_in_data, i_in_valid, i_out_ready,
    input  o_in_ready, o_out_data, o_out_valid
  );
endinterface

// File: rtl/rsa_stream_wrapper.sv
// Byte-stream front end for the RSA decryption core: loads N, d, then ciphertext blocks, returns plaintext bytes.
// Option RSA_FULL_OUTPUT_EN: send all result bytes; default drops the (always zero) top byte.
module rsa_stream_wrapper #(
  parameter int W_BYTES = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rsa_stream_wrapper_if.slave  s,
  output logic                 o_core_start,
  output logic [8*W_BYTES-1:0] o_core_n,
  output logic [8*W_BYTES-1:0] o_core_d,
  output logic [8*W_BYTES-1:0] o_core_a,
  input  logic [8*W_BYTES-1:0] i_core_a_pow_d,
  input  logic                 i_core_finished
);
  localparam int W = 8 * W_BYTES;
  localparam logic [5:0] CNT_LAST = 6'(W_BYTES - 1);
`ifdef RSA_FULL_OUTPUT_EN
  localparam logic [5:0] CNT_FIRST = 6'd0;
  localparam int         OUT_SHIFT = 0;
`else
  // Starting one count in leaves one fewer handshake; the top result byte is shifted out at capture.
  localparam logic [5:0] CNT_FIRST = 6'd1;
  localparam int         OUT_SHIFT = 8;
`endif

  typedef enum logic [2:0] {
    S_GET_N,
    S_GET_D,
    S_GET_A,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [5:0]   r_cnt, w_cnt_nxt;
  logic [W-1:0] r_n, r_d, r_a, r_out;
  logic         w_in_fire, w_out_fire, w_capture, w_cnt_last;

  assign w_cnt_last   = (r_cnt == CNT_LAST);
  assign o_core_n     = r_n;
  assign o_core_d     = r_d;
  assign o_core_a     = r_a;
  assign s.o_out_data = r_out[W-1 -: 8];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_GET_N;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    s.o_in_ready  = 1'b0;
    s.o_out_valid = 1'b0;
    o_core_start  = 1'b0;
    w_in_fire     = 1'b0;
    w_out_fire    = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_GET_N, S_GET_D, S_GET_A: begin
        s.o_in_ready = 1'b1;
        w_in_fire    = s.i_in_valid;
        if (w_in_fire) begin
          if (w_cnt_last) begin
            w_cnt_nxt = 6'd0;
            if (r_state == S_GET_N)      w_state_nxt = S_GET_D;
            else if (r_state == S_GET_D) w_state_nxt = S_GET_A;
            else                         w_state_nxt = S_START;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      S_START: begin
        o_core_start = 1'b1;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_FIRST;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        s.o_out_valid = 1'b1;
        w_out_fire    = s.i_out_ready;
        if (w_out_fire) begin
          if (w_cnt_last) begin
            w_cnt_nxt   = 6'd0;
            w_state_nxt = S_GET_A;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      default: w_state_nxt = S_GET_N;
    endcase
  end

  // Operand shift-in and result shift-out registers; all cleared by reset so an abort leaves nothing behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_n   <= '0;
      r_d   <= '0;
      r_a   <= '0;
      r_out <= '0;
    end else begin
      if (w_in_fire) begin
        case (r_state)
          S_GET_N: r_n <= {r_n[W-9:0], s.i_in_data};
          S_GET_D: r_d <= {r_d[W-9:0], s.i_in_data};
          S_GET_A: r_a <= {r_a[W-9:0], s.i_in_data};
          default: ;
        endcase
      end
      if (w_capture)
        r_out <= i_core_a_pow_d << OUT_SHIFT;
      else if (w_out_fire)
        r_out <= {r_out[W-9:0], 8'h00};
    end
  end
endmodule

// File: tb/tb_rsa_stream_wrapper.sv
// Self-checking bench for rsa_stream_wrapper: core model returns a^d after 10 cycles; expected plaintext from plain arithmetic.
`timescale 1ns/1ps
module tb_rsa_stream_wrapper;
  localparam int NB = 32;
  localparam int W  = 8 * NB;
`ifdef RSA_FULL_OUTPUT_EN
  localparam int OUT_N = 32;
`else
  localparam int OUT_N = 31;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rsa_stream_wrapper_if sif();
  logic         core_start, fin_m, fin_spur, core_fin;
  logic [W-1:0] core_n, core_d, core_a, res_m;
  int           cnt_m;
  assign core_fin = fin_m | fin_spur;

  rsa_stream_wrapper #(.W_BYTES(NB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .s              (sif),
    .o_core_start   (core_start),
    .o_core_n       (core_n),
    .o_core_d       (core_d),
    .o_core_a       (core_a),
    .i_core_a_pow_d (res_m),
    .i_core_finished(core_fin)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: finished pulse 10 cycles after start, result a ^ d.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_m <= 0;
      fin_m <= 1'b0;
      res_m <= '0;
    end else begin
      fin_m <= 1'b0;
      if (core_start) begin
        cnt_m <= 10;
        res_m <= core_a ^ core_d;
      end else if (cnt_m != 0) begin
        cnt_m <= cnt_m - 1;
        if (cnt_m == 1) fin_m <= 1'b1;
      end
    end
  end

  // Output monitor: collects handshaken bytes and checks hold-while-stalled.
  logic [7:0] rx_q[$];
  int         cyc = 0, first_hs = 0, last_hs = 0, n_start = 0;
  logic       stall_p = 1'b0;
  logic [7:0] held_p  = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (core_start) n_start <= n_start + 1;
      if (stall_p) begin
        check_val("hold_valid", W'(sif.o_out_valid), W'(1'b1));
        check_val("hold_data", W'(sif.o_out_data), W'(held_p));
      end
      if (sif.o_out_valid && sif.i_out_ready) begin
        if (rx_q.size() == 0) first_hs <= cyc;
        last_hs <= cyc;
        rx_q.push_back(sif.o_out_data);
      end
      stall_p <= sif.o_out_valid && !sif.i_out_ready;
      held_p  <= sif.o_out_data;
    end else begin
      stall_p <= 1'b0;
    end
  end

  // Sink ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  int rdy_mode = 0;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    ph = ph + 1;
    case (rdy_mode)
      0:       sif.i_out_ready = 1'b1;
      1:       sif.i_out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      default: sif.i_out_ready = 1'($urandom_range(1, 0));
    endcase
  end

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int i = 0; i < NB / 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit fire, done;
    done = 1'b0;
    if (gap > 0 && $urandom_range(99, 0) < gap) begin
      sif.i_in_valid = 1'b0;
      repeat ($urandom_range(3, 1)) begin
        sif.i_in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    sif.i_in_data  = b;
    sif.i_in_valid = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      fire = sif.o_in_ready;
      @(posedge clk); #1;
      if (fire) done = 1'b1;
    end
    sif.i_in_valid = 1'b0;
    if (!done) check_val("in_timeout", W'(1'b0), W'(1'b1));
  endtask

  task automatic send_operand(input logic [W-1:0] v, input int gap);
    for (int i = 0; i < NB; i++) send_byte(v[8*(NB-1-i) +: 8], gap);
  endtask

  task automatic run_block(input logic [W-1:0] a, input logic [W-1:0] d, input int gap, input bit consec);
    int s0;
    bit done;
    logic [W-1:0] res;
    rx_q.delete();
    s0 = n_start;
    send_operand(a, gap);
    check_val("start_pulse", W'(core_start), W'(1'b1));
    check_val("in_ready_busy", W'(sif.o_in_ready), W'(1'b0));
    @(posedge clk); #1;
    check_val("start_one_cycle", W'(core_start), W'(1'b0));
    check_val("core_a", core_a, a);
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      if (sif.o_in_ready) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check_val("out_timeout", W'(1'b0), W'(1'b1));
    check_val("n_bytes", W'(rx_q.size()), W'(OUT_N));
    check_val("valid_after_last", W'(sif.o_out_valid), W'(1'b0));
    check_val("ready_after_last", W'(cyc), W'(last_hs + 1));
    check_val("start_count", W'(n_start - s0), W'(1));
    if (consec) check_val("consecutive", W'(last_hs - first_hs), W'(OUT_N - 1));
    res = a ^ d;
    for (int k = 0; k < OUT_N && k < rx_q.size(); k++)
      check_val($sformatf("out_byte%0d", k), W'(rx_q[k]), W'(res[8*(OUT_N-1-k) +: 8]));
  endtask

  logic [W-1:0] n_v, d_v, a_v;
  bit           hit;

  initial begin
    sif.i_in_data   = 8'h00;
    sif.i_in_valid  = 1'b0;
    sif.i_out_ready = 1'b1;
    fin_spur        = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", W'(sif.o_in_ready), W'(1'b1));
    check_val("rst_out_valid", W'(sif.o_out_valid), W'(1'b0));
    check_val("rst_out_data", W'(sif.o_out_data), W'(8'h00));
    check_val("rst_start", W'(core_start), W'(1'b0));
    check_val("rst_core_n", core_n, '0);
    check_val("rst_core_d", core_d, '0);
    check_val("rst_core_a", core_a, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed block: N = 01..20, d = FF.., a = 00..1F.
    for (int i = 0; i < NB; i++) begin
      n_v[8*(NB-1-i) +: 8] = 8'(i + 1);
      a_v[8*(NB-1-i) +: 8] = 8'(i);
    end
    d_v = '1;
    send_operand(n_v, 0);
    send_operand(d_v, 0);
    check_val("core_n", core_n, n_v);
    check_val("core_d", core_d, d_v);
    run_block(a_v, d_v, 0, 1'b1);

    // Second block with retained keys.
    run_block({NB{8'hAA}}, d_v, 0, 1'b1);
    check_val("keys_kept_n", core_n, n_v);
    check_val("keys_kept_d", core_d, d_v);

    // Backpressure 1,0,0,1 and source gaps with random operands.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    n_v = rand_op();
    d_v = rand_op();
    send_operand(n_v, 30);
    send_operand(d_v, 30);
    check_val("gap_core_n", core_n, n_v);
    check_val("gap_core_d", core_d, d_v);
    run_block(rand_op(), d_v, 30, 1'b0);

    // Random sink ready, several random blocks.
    rdy_mode = 2;
    for (int b = 0; b < 3; b++) run_block(rand_op(), d_v, 20, 1'b0);

    // Reset in the middle of output.
    rdy_mode = 0;
    rx_q.delete();
    send_operand(rand_op(), 0);
    hit = 1'b0;
    for (int t = 0; t < 500 && !hit; t++) begin
      @(posedge clk); #1;
      if (rx_q.size() >= 5) hit = 1'b1;
    end
    if (!hit) check_val("send5_timeout", W'(1'b0), W'(1'b1));
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", W'(sif.o_out_valid), W'(1'b0));
    check_val("midrst_out_data", W'(sif.o_out_data), W'(8'h00));
    check_val("midrst_in_ready", W'(sif.o_in_ready), W'(1'b1));
    check_val("midrst_core_n", core_n, '0);
    check_val("midrst_core_d", core_d, '0);
    check_val("midrst_core_a", core_a, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reload, spurious finished while loading ciphertext, then a correct block.
    n_v = rand_op();
    d_v = rand_op();
    send_operand(n_v, 0);
    send_operand(d_v, 0);
    fin_spur = 1'b1;
    @(posedge clk); #1;
    fin_spur = 1'b0;
    for (int t = 0; t < 3; t++) begin
      check_val("spur_out_valid", W'(sif.o_out_valid), W'(1'b0));
      check_val("spur_in_ready", W'(sif.o_in_ready), W'(1'b1));
      @(posedge clk); #1;
    end
    run_block(rand_op(), d_v, 0, 1'b1);
    check_val("reload_core_n", core_n, n_v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
